// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC -> imem req/ack handshake -> IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_write,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            flush,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0] ifid_instr,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_wait_cnt
`else
  output logic [XLEN-1:0] ifid_instr
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [XLEN-1:0]   hold_pc_r;
  logic [XLEN-1:0]   hold_instr_r;
  logic              pc_write_s;
  logic              fetch_load_s;
  logic              hold_load_s;
  logic              capture_s;
  logic              bubble_s;
  logic              discard_s;

  assign imem_req  = (state_r == ST_REQ);
  assign imem_addr = {pc_in[XLEN-1:2], 2'b00};
  assign pc_write  = pc_write_s;

  // Next-state and IF/ID update decisions; flush outranks stall outside IDLE.
  always_comb begin
    state_nxt_s  = state_r;
    pc_write_s   = 1'b0;
    fetch_load_s = 1'b0;
    hold_load_s  = 1'b0;
    capture_s    = 1'b0;
    bubble_s     = 1'b0;
    discard_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (flush) begin
          pc_write_s = 1'b1;
          bubble_s   = 1'b1;
          discard_s  = 1'b1;
        end else if (imem_ack && !stall) begin
          pc_write_s   = 1'b1;
          fetch_load_s = 1'b1;
        end else if (imem_ack && stall) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HOLD;
        end else if (!stall) begin
          bubble_s = 1'b1;
        end else begin
          bubble_s = 1'b0;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_write_s  = 1'b1;
          bubble_s    = 1'b1;
          discard_s   = 1'b1;
          state_nxt_s = ST_REQ;
        end else if (!stall) begin
          pc_write_s  = 1'b1;
          hold_load_s = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, hold buffer and IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      hold_pc_r     <= {XLEN{1'b0}};
      hold_instr_r  <= NOP_INSTR;
      ifid_valid    <= 1'b0;
      ifid_pc       <= {XLEN{1'b0}};
      ifid_pc_plus4 <= {XLEN{1'b0}};
      ifid_instr    <= NOP_INSTR;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        hold_pc_r    <= pc_in;
        hold_instr_r <= imem_rdata;
      end else if (discard_s) begin
        hold_pc_r    <= {XLEN{1'b0}};
        hold_instr_r <= NOP_INSTR;
      end
      // Bubbles keep the pc fields; only valid and the instruction change.
      if (bubble_s) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end else if (fetch_load_s) begin
        ifid_valid    <= 1'b1;
        ifid_pc       <= pc_in;
        ifid_pc_plus4 <= pc_in + PC_STEP;
        ifid_instr    <= imem_rdata;
      end else if (hold_load_s) begin
        ifid_valid    <= 1'b1;
        ifid_pc       <= hold_pc_r;
        ifid_pc_plus4 <= hold_pc_r + PC_STEP;
        ifid_instr    <= hold_instr_r;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Fetches that are kept, and request cycles spent waiting for memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_wait_cnt  <= 32'd0;
    end else begin
      if (imem_req && imem_ack && !flush) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (imem_req && !imem_ack) begin
        perf_wait_cnt <= perf_wait_cnt + 32'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-level behavioural model checked
// every negedge, plus literal spot checks at the interesting points.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = 32'd0;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_stage #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_write(pc_write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
`ifdef FETCH_PERF_EN
    .ifid_instr(ifid_instr),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_wait_cnt(perf_wait_cnt)
`else
    .ifid_instr(ifid_instr)
`endif
  );

  always #5 clk = ~clk;

  // Model: "fresh" = first cycle after reset; a non-empty held queue means
  // a fetched instruction is parked waiting for the stall to clear.
  logic        m_fresh;
  logic        m_valid;
  logic [31:0] m_pc, m_pc4, m_instr;
  logic [63:0] held_q[$];
  logic [31:0] m_fetches, m_waits;

  function automatic void model_reset();
    m_fresh = 1'b1; m_valid = 1'b0; m_pc = 32'd0; m_pc4 = 32'd0;
    m_instr = NOP; held_q.delete(); m_fetches = 32'd0; m_waits = 32'd0;
  endfunction

  function automatic logic exp_req();
    return !rst && !m_fresh && (held_q.size() == 0);
  endfunction

  function automatic logic exp_pc_write();
    if (rst || m_fresh) return 1'b0;
    if (flush) return 1'b1;
    if (held_q.size() != 0) return !stall;
    return imem_ack && !stall;
  endfunction

  function automatic void model_edge();
    logic [63:0] e;
    if (rst) begin
      model_reset();
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else begin
      if (exp_req() && imem_ack && !flush) m_fetches = m_fetches + 32'd1;
      if (exp_req() && !imem_ack) m_waits = m_waits + 32'd1;
      if (flush) begin
        m_valid = 1'b0; m_instr = NOP; held_q.delete();
      end else if (held_q.size() != 0) begin
        if (!stall) begin
          e = held_q.pop_front();
          m_valid = 1'b1; m_pc = e[63:32]; m_pc4 = e[63:32] + 32'd4; m_instr = e[31:0];
        end
      end else if (imem_ack) begin
        if (stall) held_q.push_back({pc_in, imem_rdata});
        else begin
          m_valid = 1'b1; m_pc = pc_in; m_pc4 = pc_in + 32'd4; m_instr = imem_rdata;
        end
      end else if (!stall) begin
        m_valid = 1'b0; m_instr = NOP;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    chk("pc_write", {31'd0, pc_write}, {31'd0, exp_pc_write()});
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req()});
    chk("imem_addr", imem_addr, pc_in & 32'hFFFF_FFFC);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("ifid_pc", ifid_pc, m_pc);
    chk("ifid_pc_plus4", ifid_pc_plus4, m_pc4);
    chk("ifid_instr", ifid_instr, m_instr);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetches);
    chk("perf_wait_cnt", perf_wait_cnt, m_waits);
`endif
  end

  task automatic step(input logic [31:0] pc, input logic a, input logic [31:0] d,
                      input logic s, input logic f);
    pc_in = pc; imem_ack = a; imem_rdata = d; stall = s; flush = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    step(32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    // Zero-wait fetch stream 0,4,8.
    step(32'd0, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
    step(32'd0, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
    chk("lit_first_pc", ifid_pc, 32'd0);
    chk("lit_first_valid", {31'd0, ifid_valid}, 32'd1);
    step(32'd4, 1'b1, 32'h1000_0004, 1'b0, 1'b0);
    step(32'd8, 1'b1, 32'h1000_0008, 1'b0, 1'b0);
    chk("lit_pc8", ifid_pc, 32'd8);
    chk("lit_pc8_plus4", ifid_pc_plus4, 32'd12);
    // Two wait cycles at 0x100.
    step(32'h100, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("lit_bubble_instr", ifid_instr, 32'd0);
    step(32'h100, 1'b0, 32'd0, 1'b0, 1'b0);
    step(32'h100, 1'b1, 32'hCAFE_0100, 1'b0, 1'b0);
    chk("lit_wait_pc4", ifid_pc_plus4, 32'h104);
    chk("lit_wait_instr", ifid_instr, 32'hCAFE_0100);
    // No-ack stall keeps IF/ID; then ack with stall parks the instruction.
    step(32'h200, 1'b0, 32'd0, 1'b1, 1'b0);
    step(32'h200, 1'b1, 32'h2108_0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h204, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("lit_stall_old", ifid_instr, 32'hCAFE_0100);
    step(32'h204, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("lit_hold_pc", ifid_pc, 32'h200);
    chk("lit_hold_instr", ifid_instr, 32'h2108_0001);
    // Flush with stall while holding.
    step(32'h300, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(32'h300, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("lit_flush_valid", {31'd0, ifid_valid}, 32'd0);
    step(32'h400, 1'b0, 32'd0, 1'b0, 1'b0);
    step(32'h400, 1'b1, 32'h1111_0400, 1'b0, 1'b0);
    chk("lit_after_flush", ifid_instr, 32'h1111_0400);
    // Flush in REQ drops a same-cycle ack.
    step(32'h500, 1'b1, 32'h2222_0500, 1'b0, 1'b1);
    step(32'h600, 1'b1, 32'h3333_0600, 1'b1, 1'b1);
    // Wraparound and misaligned PC.
    step(32'hFFFF_FFFC, 1'b1, 32'h4444_0000, 1'b0, 1'b0);
    chk("lit_wrap_plus4", ifid_pc_plus4, 32'd0);
    step(32'h0000_0103, 1'b1, 32'h5555_0103, 1'b0, 1'b0);
    chk("lit_misaligned_pc", ifid_pc, 32'h0000_0103);
    // Reset in the middle of an outstanding request.
    step(32'h700, 1'b0, 32'd0, 1'b0, 1'b0);
    pc_in = 32'h700; imem_ack = 1'b0; stall = 1'b0; flush = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("lit_rst_req", {31'd0, imem_req}, 32'd0);
    chk("lit_rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("lit_rst_pc", ifid_pc, 32'd0);
    chk("lit_rst_pc_write", {31'd0, pc_write}, 32'd0);
    step(32'h700, 1'b1, 32'd1, 1'b0, 1'b0);
    rst = 1'b0;
    step(32'h700, 1'b1, 32'h7777_0700, 1'b0, 1'b1);
    step(32'h700, 1'b1, 32'h7777_0700, 1'b0, 1'b0);
    step(32'h704, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("lit_post_rst_pc", ifid_pc, 32'h700);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
